// File: rtl/uart_loader.sv
// Serial boot monitor: host commands over the UART write and read RAM bytes,
// then launch the CPU and report back when it halts.
module uart_loader #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  received,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    input  logic                  is_transmitting,
    output logic [addr_width-1:0] raddr,
    output logic [addr_width-1:0] waddr,
    output logic [7:0]            dwrite,
    output logic                  write_en,
    input  logic [7:0]            dread,
    output logic                  loader_active,
    output logic                  cpu_start,
    output logic [addr_width-1:0] startaddr,
    input  logic                  cpu_halted
);

    typedef enum logic [4:0] {
        IDLE, W_AH, W_AL, W_LEN, W_DATA,
        R_AH, R_AL, R_LEN, R_ADDR, R_WAIT, R_CAP,
        G_AH, G_AL, G_START, RUN, TX, TX_GUARD
    } state_t;

    state_t                state, ret_state;
    logic [7:0]            hi, reply;
    logic [addr_width-1:0] addr;
    logic [8:0]            count;

    // Address bits above addr_width are silently dropped; a zero length means 256.
    logic [15:0]           full_addr;
    logic [addr_width-1:0] rx_addr;
    logic [8:0]            rx_len;
    assign full_addr = {hi, rx_byte};
    assign rx_addr   = full_addr[addr_width-1:0];
    assign rx_len    = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ret_state     <= IDLE;
            hi            <= '0;
            reply         <= '0;
            addr          <= '0;
            count         <= '0;
            tx_byte       <= '0;
            transmit      <= 1'b0;
            raddr         <= '0;
            waddr         <= '0;
            dwrite        <= '0;
            write_en      <= 1'b0;
            loader_active <= 1'b1;
            cpu_start     <= 1'b0;
            startaddr     <= '0;
        end else begin
            transmit  <= 1'b0;
            write_en  <= 1'b0;
            cpu_start <= 1'b0;
            case (state)
                IDLE: if (received) begin
                    case (rx_byte)
                        8'h57:   state <= W_AH;
                        8'h52:   state <= R_AH;
                        8'h47:   state <= G_AH;
                        default: begin
                            reply     <= 8'h3F;
                            ret_state <= IDLE;
                            state     <= TX;
                        end
                    endcase
                end
                W_AH: if (received) begin hi <= rx_byte; state <= W_AL; end
                W_AL: if (received) begin addr <= rx_addr; state <= W_LEN; end
                W_LEN: if (received) begin count <= rx_len; state <= W_DATA; end
                W_DATA: if (received) begin
                    write_en <= 1'b1;
                    waddr    <= addr;
                    dwrite   <= rx_byte;
                    addr     <= addr + 1'b1;
                    count    <= count - 1'b1;
                    if (count == 9'd1) begin
                        reply     <= 8'h4B;
                        ret_state <= IDLE;
                        state     <= TX;
                    end
                end
                R_AH: if (received) begin hi <= rx_byte; state <= R_AL; end
                R_AL: if (received) begin addr <= rx_addr; state <= R_LEN; end
                R_LEN: if (received) begin count <= rx_len; state <= R_ADDR; end
                R_ADDR: begin raddr <= addr; state <= R_WAIT; end
                // Synchronous RAM: dread is valid two cycles after raddr moves.
                R_WAIT: state <= R_CAP;
                R_CAP: begin
                    reply     <= dread;
                    addr      <= addr + 1'b1;
                    count     <= count - 1'b1;
                    ret_state <= (count == 9'd1) ? IDLE : R_ADDR;
                    state     <= TX;
                end
                G_AH: if (received) begin hi <= rx_byte; state <= G_AL; end
                G_AL: if (received) begin
                    addr          <= rx_addr;
                    startaddr     <= rx_addr;
                    loader_active <= 1'b0;
                    state         <= G_START;
                end
                G_START: begin cpu_start <= 1'b1; state <= RUN; end
                RUN: if (cpu_halted) begin
                    loader_active <= 1'b1;
                    reply         <= 8'h48;
                    ret_state     <= IDLE;
                    state         <= TX;
                end
                TX: if (!is_transmitting) begin
                    tx_byte  <= reply;
                    transmit <= 1'b1;
                    state    <= TX_GUARD;
                end
                // The transmitter may raise busy a cycle late; skip it once.
                TX_GUARD: state <= ret_state;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: host command sequences against a byte-level RAM
// reference model plus a simple busy-UART and synchronous-RAM environment.
module tb_uart_loader;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_byte = '0;
    logic          received = 1'b0;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic          is_transmitting;
    logic [AW-1:0] raddr, waddr, startaddr;
    logic [7:0]    dwrite;
    logic          write_en;
    logic [7:0]    dread;
    logic          loader_active, cpu_start;
    logic          cpu_halted = 1'b0;

    uart_loader #(.addr_width(AW)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .received(received),
        .tx_byte(tx_byte), .transmit(transmit), .is_transmitting(is_transmitting),
        .raddr(raddr), .waddr(waddr), .dwrite(dwrite), .write_en(write_en),
        .dread(dread), .loader_active(loader_active), .cpu_start(cpu_start),
        .startaddr(startaddr), .cpu_halted(cpu_halted)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:511];
    logic [7:0] ref_mem [0:511];
    int         busy_cnt;
    int         txq[$];
    int         wa_q[$];
    int         wd_q[$];
    logic [7:0] wdata[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART transmitter: busy for a random stretch after each transmit.
    assign is_transmitting = (busy_cnt != 0);
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (transmit) busy_cnt <= $urandom_range(3, 12);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Synchronous-read RAM.
    always @(posedge clk) begin
        if (write_en) mem[waddr] <= dwrite;
        dread <= mem[raddr];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (transmit) begin
                txq.push_back(int'(tx_byte));
                check("tx_while_busy", is_transmitting, 0);
            end
            if (write_en) begin
                wa_q.push_back(int'(waddr));
                wd_q.push_back(int'(dwrite));
                check("we_while_cpu", loader_active, 1);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic get_reply(input string tag, input logic [7:0] exp);
        int n = 0;
        while (txq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (txq.size() == 0) check({tag, "_timeout"}, txq.size(), 1);
        else check(tag, txq.pop_front(), {24'd0, exp});
    endtask

    task automatic do_write(input logic [15:0] a, input int len);
        int ea;
        wa_q.delete();
        wd_q.delete();
        txq.delete();
        send(8'h57);
        send(a[15:8]);
        send(a[7:0]);
        send((len == 256) ? 8'h00 : len[7:0]);
        for (int i = 0; i < len; i++) send(wdata[i]);
        get_reply("W_ack", 8'h4B);
        check("W_count", wa_q.size(), len);
        for (int i = 0; i < len; i++) begin
            ea = (int'(a[AW-1:0]) + i) % 512;
            ref_mem[ea] = wdata[i];
            if (i < wa_q.size()) begin
                check("W_addr", wa_q[i], ea);
                check("W_data", wd_q[i], {24'd0, wdata[i]});
            end
        end
    endtask

    task automatic do_read(input logic [15:0] a, input int len);
        txq.delete();
        send(8'h52);
        send(a[15:8]);
        send(a[7:0]);
        send((len == 256) ? 8'h00 : len[7:0]);
        for (int i = 0; i < len; i++)
            get_reply("R_data", ref_mem[(int'(a[AW-1:0]) + i) % 512]);
        repeat (40) @(negedge clk);
        check("R_no_trailer", txq.size(), 0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  ub;
        int          rl;

        repeat (3) @(negedge clk);
        check("rst_active", loader_active, 1);
        check("rst_transmit", transmit, 0);
        check("rst_write_en", write_en, 0);
        check("rst_cpu_start", cpu_start, 0);
        check("rst_tx_byte", tx_byte, 0);
        check("rst_dwrite", dwrite, 0);
        check("rst_raddr", raddr, 0);
        check("rst_waddr", waddr, 0);
        check("rst_startaddr", startaddr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        wdata = '{8'hAA, 8'hBB, 8'hCC};
        do_write(16'h0010, 3);
        do_read(16'h0010, 3);

        wdata = '{8'h11, 8'h22};
        do_write(16'h01FF, 2);
        do_read(16'h01FF, 2);

        wdata = '{8'h99};
        do_write(16'hFE05, 1);

        wdata.delete();
        for (int i = 0; i < 256; i++) wdata.push_back(8'($urandom));
        do_write(16'h0000, 256);
        do_read(16'h00F8, 8);
        do_read(16'h01FF, 2);

        txq.delete();
        send(8'h5A);
        get_reply("unknown_cmd", 8'h3F);

        // Launch, ignore bytes while running, then halt with a coincident byte.
        txq.delete();
        send(8'h47);
        send(8'h00);
        check("G_active_before", loader_active, 1);
        @(negedge clk);
        rx_byte  = 8'h20;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        check("G_active_low", loader_active, 0);
        check("G_startaddr", startaddr, 32'h20);
        check("G_start_early", cpu_start, 0);
        @(negedge clk);
        check("G_cpu_start", cpu_start, 1);
        @(negedge clk);
        check("G_start_once", cpu_start, 0);
        wa_q.delete();
        send(8'h57);
        send(8'h00);
        send(8'h3F);
        check("RUN_no_write", wa_q.size(), 0);
        check("RUN_no_tx", txq.size(), 0);
        check("RUN_active", loader_active, 0);
        @(negedge clk);
        cpu_halted = 1'b1;
        rx_byte    = 8'h52;
        received   = 1'b1;
        @(negedge clk);
        cpu_halted = 1'b0;
        received   = 1'b0;
        check("halt_active", loader_active, 1);
        get_reply("halt_H", 8'h48);
        do_read(16'h0010, 2);

        // Reset after the first of three data bytes.
        wa_q.delete();
        txq.delete();
        send(8'h57);
        send(8'h00);
        send(8'h30);
        send(8'h03);
        send(8'h77);
        ref_mem[9'h030] = 8'h77;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_writes", wa_q.size(), 1);
        if (wa_q.size() > 0) check("rstmid_addr", wa_q[0], 32'h30);
        repeat (30) @(negedge clk);
        check("rstmid_no_ack", txq.size(), 0);
        check("rstmid_active", loader_active, 1);
        do_read(16'h0030, 3);

        for (int k = 0; k < 8; k++) begin
            ra = 16'($urandom);
            rl = $urandom_range(1, 6);
            wdata.delete();
            for (int i = 0; i < rl; i++) wdata.push_back(8'($urandom));
            do_write(ra, rl);
            do_read(ra, rl);
            ub = 8'($urandom);
            if (ub == 8'h57 || ub == 8'h52 || ub == 8'h47) ub = ub ^ 8'h80;
            txq.delete();
            send(ub);
            get_reply("rand_unknown", 8'h3F);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
- Serial monitor/boot stage directly upstream of the CPU.
- Owns the RAM ports and the UART while the CPU is idle.
- Accepts host commands over the UART receiver to write and read RAM bytes, then launches the CPU at a given address.
- Waits for the CPU to halt and reports the halt back to the host.

Parameters:
addr_width, 9, RAM address width; must match the CPU's addr_width (range 9..16).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rx_byte  in  8  byte from UART receiver
received  in  1  one-cycle strobe, rx_byte valid
tx_byte  out  8  byte to UART transmitter
transmit  out  1  one-cycle strobe, start sending tx_byte
is_transmitting  in  1  UART transmitter busy
raddr  out  addr_width  RAM read address
waddr  out  addr_width  RAM write address
dwrite  out  8  RAM write data
write_en  out  1  RAM write strobe
dread  in  8  RAM read data
loader_active  out  1  1 = loader drives RAM/UART (external mux select), 0 = CPU drives them
cpu_start  out  1  one-cycle strobe to CPU rst input
startaddr  out  addr_width  CPU start address
cpu_halted  in  1  CPU halted strobe

Behaviour:
- Reset: clk is the clock; rst is synchronous, active-high.
  - On reset: state IDLE, loader_active=1; transmit, write_en, cpu_start = 0.
  - tx_byte, dwrite, raddr, waddr, startaddr = 0; internal addr/count = 0.
  - Reset mid-command aborts with no reply; any partial write already performed stays in RAM.
- Outputs: all outputs are registered. Strobes (transmit, write_en, cpu_start) are high for exactly one cycle.
- Address assembly: address = {hi, lo}[addr_width-1:0]; upper bits beyond addr_width are ignored. Increments wrap modulo 2^addr_width. Length byte 0 means 256.
- IDLE: on received, decode rx_byte:
  - 0x57 'W' -> W_AH
  - 0x52 'R' -> R_AH
  - 0x47 'G' -> G_AH
  - any other byte -> queue reply 0x3F '?' and go to TX.
- Argument states: *_AH captures hi and *_AL captures lo, each on the next received. W and R then enter *_LEN and capture len. Non-strobe cycles hold state.
- W_DATA: each received byte produces next-cycle write_en=1, waddr=addr, dwrite=rx_byte; then addr++ and count--. After the last byte, reply 0x4B 'K'.
- R flow: R_ADDR sets raddr=addr → R_WAIT (1 cycle) → R_CAP latches dread (valid in the 2nd cycle after raddr changes) → TX of that byte. Then addr++, count--. Repeat while count≠0, then IDLE. No trailing 'K'.
- G flow: after lo is captured:
  - Set startaddr=addr and loader_active=0 in the same cycle; pulse cpu_start the following cycle; go to RUN.
- RUN: received bytes are ignored by the loader. On cpu_halted: loader_active=1, reply 0x48 'H', then IDLE.
- TX: wait for !is_transmitting, drive tx_byte and pulse transmit. Then TX_GUARD, one cycle that ignores is_transmitting, to cover UART busy assertion latency. Then return to the calling state (IDLE, or R_ADDR for the next byte).
- Dropped bytes: bytes received during TX, TX_GUARD, R_* or RUN are dropped. The host must wait for each reply before sending further bytes.
- Simultaneous events:
  - received and cpu_halted in the same cycle in RUN: halt is handled, the byte is dropped.
  - rst has priority over everything.
- RAM ports:
  - write_en is never asserted while loader_active=0.
  - raddr and waddr are held when not in use.

Test Plan:
- Reset then 'W',0x00,0x10,0x03,0xAA,0xBB,0xCC -> writes 0x010=AA, 0x011=BB, 0x012=CC, one write_en each; tx 'K' (0x4B).
- 'R',0x00,0x10,0x03 after the above -> tx AA, BB, CC in order; transmit never pulses while is_transmitting=1.
- 'W',0x01,0xFF,0x02,0x11,0x22 (addr_width=9) -> writes 0x1FF=11, 0x000=22 (wrap); 'W',0xFE,0x05,... -> address 0x005 (upper bits dropped).
- 'W',0x00,0x00,0x00 followed by 256 bytes -> 256 writes to 0x000..0x0FF, then 'K'.
- 'G',0x00,0x20 -> startaddr=0x020, loader_active falls, cpu_start pulses one cycle later; bytes sent during RUN are ignored; cpu_halted pulse -> loader_active=1, tx 'H'.
- Byte 0x5A in IDLE -> tx '?'. rst asserted mid-'W' after 1 of 3 data bytes -> IDLE, no 'K'; the next 'R' works normally.
